// File: rtl/divider_32b_iter.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, 33-cycle latency.
// Define DIVIDER_32B_ITER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module divider_32b_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] q_r;
  logic [31:0] r_r;
  logic [31:0] d_r;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

`ifdef DIVIDER_32B_ITER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic div0;

  always_comb begin
    a_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
    b_mag = divisor[31]  ? (~divisor  + 32'd1) : divisor;
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  // q_r starts as the dividend and is shifted out MSB first while quotient bits shift in.
  // A clear borrow bit means the partial remainder covers the divisor.
  always_comb begin
    trial = {r_r, q_r[31]};
    diff  = trial - {1'b0, d_r};
    qbit  = ~diff[32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
`ifdef DIVIDER_32B_ITER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            q_r   <= a_mag;
            r_r   <= '0;
            d_r   <= b_mag;
            cnt   <= '0;
`ifdef DIVIDER_32B_ITER_SIGNED_EN
            neg_q <= dividend[31] ^ divisor[31];
            neg_r <= dividend[31];
            div0  <= (divisor == '0);
`endif
            state <= CALC;
          end
        end
        CALC: begin
          q_r <= {q_r[30:0], qbit};
          r_r <= qbit ? diff[31:0] : trial[31:0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          if (ostream_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign istream_rdy = (state == IDLE) && !rst;
  assign ostream_val = (state == DONE);

`ifdef DIVIDER_32B_ITER_SIGNED_EN
  // Magnitude division by zero yields all-ones with rem=|dividend|; re-signing rem restores the dividend.
  assign quot = div0  ? '1 : (neg_q ? (~q_r + 32'd1) : q_r);
  assign rem  = neg_r ? (~r_r + 32'd1) : r_r;
`else
  assign quot = q_r;
  assign rem  = r_r;
`endif

endmodule

// File: tb/tb_divider_32b_iter.sv
// Directed and randomized checks of divider_32b_iter: latency, handshakes, stalls, reset abort.
module tb_divider_32b_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] quot;
  logic [31:0] rem;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_results = 0;

  always #5 clk = ~clk;

  divider_32b_iter dut (
    .clk         (clk),
    .rst         (rst),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .dividend    (dividend),
    .divisor     (divisor),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .quot        (quot),
    .rem         (rem)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
`ifdef DIVIDER_32B_ITER_SIGNED_EN
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
`else
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endtask

  // Handshake a request; afterwards operands are scrambled to prove they were captured.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hold_val);
    int unsigned w;
    @(negedge clk);
    istream_val = 1'b1;
    dividend    = a;
    divisor     = b;
    w = 0;
    while (!istream_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_rdy", {31'b0, istream_rdy}, 32'd1);
    @(posedge clk); #1;
    istream_val = hold_val;
    dividend    = ~a;
    divisor     = b ^ 32'h5A5A_1234;
    check("rdy_in_calc", {31'b0, istream_rdy}, 32'd0);
  endtask

  task automatic finish_resp(input logic [31:0] eq, input logic [31:0] er, input int unsigned stall);
    int unsigned lat;
    lat = 1;
    while (!ostream_val && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    istream_val = 1'b0;
    check("latency", lat, 32'd33);
    if (ostream_val) n_results++;
    check("quot", quot, eq);
    check("rem", rem, er);
    for (int unsigned s = 0; s < stall; s++) begin
      ostream_rdy = 1'b0;
      @(posedge clk); #1;
      check("stall_val", {31'b0, ostream_val}, 32'd1);
      check("stall_irdy", {31'b0, istream_rdy}, 32'd0);
      check("stall_quot", quot, eq);
      check("stall_rem", rem, er);
    end
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
    check("val_after_resp", {31'b0, ostream_val}, 32'd0);
    check("irdy_after_resp", {31'b0, istream_rdy}, 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input int unsigned stall, input bit hold_val);
    send(a, b, hold_val);
    finish_resp(eq, er, stall);
  endtask

  initial begin
    logic [31:0] ra, rb, mq, mr;
    rst = 1'b1;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irdy", {31'b0, istream_rdy}, 32'd0);
    check("rst_oval", {31'b0, ostream_val}, 32'd0);
    check("rst_quot", quot, 32'd0);
    check("rst_rem", rem, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("irdy_after_rst", {31'b0, istream_rdy}, 32'd1);

    // Requests raised during CALC must be ignored.
    run(32'd100, 32'd7, 32'd14, 32'd2, 0, 1'b1);
    run(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, 1'b0);
    run(32'd50, 32'd5, 32'd10, 32'd0, 10, 1'b0);
    run(32'd3, 32'd10, 32'd0, 32'd3, 1, 1'b0);
`ifdef DIVIDER_32B_ITER_SIGNED_EN
    run(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1'b0);
    run(32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, 1'b0);
`else
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1'b0);
    run(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1'b0);
`endif

    // Reset in the middle of CALC aborts the operation.
    send(32'd1000, 32'd3, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_oval", {31'b0, ostream_val}, 32'd0);
    check("abort_irdy", {31'b0, istream_rdy}, 32'd0);
    check("abort_quot", quot, 32'd0);
    check("abort_rem", rem, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_irdy_after", {31'b0, istream_rdy}, 32'd1);
    n_results = 0;
    run(32'd9, 32'd4, 32'd2, 32'd1, 0, 1'b0);

    n_results = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      model(ra, rb, mq, mr);
      run(ra, rb, mq, mr, $urandom_range(0, 3), 1'b0);
    end
    check("resp_count", n_results, 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
